// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: instruction constants, field slices and the IF/ID payload.
package cpu_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned WORD_BYTES       = 4;
   localparam int unsigned DEFAULT_SIZE_IM  = 128;
   localparam int unsigned OPCODE_MSB       = 31;
   localparam int unsigned OPCODE_LSB       = 26;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef logic [OPCODE_MSB-OPCODE_LSB:0] opcode_t;

   typedef struct packed {
      logic [XLEN-1:0] instru;
      logic [XLEN-1:0] pc4;
      logic            valid;
   } ifid_t;

   function automatic opcode_t opcode_of(input logic [XLEN-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory link and IF/ID outputs.
// Perf-counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] im_instru;
   logic [31:0] im_addr;
   logic [31:0] ifid_instru;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        fetch_done;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;

   modport master (
      input  stall, flush, branch_taken, branch_target, jump, jump_target, im_instru,
      output im_addr, ifid_instru, ifid_pc4, ifid_valid, fetch_done, perf_fetched, perf_bubbles
   );
   modport slave (
      output stall, flush, branch_taken, branch_target, jump, jump_target, im_instru,
      input  im_addr, ifid_instru, ifid_pc4, ifid_valid, fetch_done, perf_fetched, perf_bubbles
   );
`else
   modport master (
      input  stall, flush, branch_taken, branch_target, jump, jump_target, im_instru,
      output im_addr, ifid_instru, ifid_pc4, ifid_valid, fetch_done
   );
   modport slave (
      output stall, flush, branch_taken, branch_target, jump, jump_target, im_instru,
      input  im_addr, ifid_instru, ifid_pc4, ifid_valid, fetch_done
   );
`endif
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with hold (stall), squash (flush/redirect) and bubble (fetch window exhausted).
module ifid_reg
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            hold_i,
   input  logic            squash_i,
   input  logic            bubble_i,
   input  logic [XLEN-1:0] instru_i,
   input  logic [XLEN-1:0] pc4_i,
   output ifid_t           ifid_o
);

   ifid_t ifid_q;
   ifid_t ifid_d;

   // Bubble keeps the last pc4; squash clears it as well.
   always_comb begin
      ifid_d = ifid_q;
      if (hold_i) begin
         ifid_d = ifid_q;
      end else if (squash_i) begin
         ifid_d = '{instru: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      end else if (bubble_i) begin
         ifid_d.instru = NOP_INSTR;
         ifid_d.valid  = 1'b0;
      end else begin
         ifid_d = '{instru: instru_i, pc4: pc4_i, valid: 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_q <= '{instru: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection and IF/ID capture for the 5-stage MIPS pipeline.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned SIZE_IM  = DEFAULT_SIZE_IM
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic            fetch_done_c;
   logic            squash_c;
   logic            load_c;
   ifid_t           ifid;

   assign pc_plus4     = pc_q + XLEN'(WORD_BYTES);
   assign fetch_done_c = {2'b00, pc_q[XLEN-1:2]} >= XLEN'(SIZE_IM);
   assign squash_c     = bus.flush | bus.jump | bus.branch_taken;
   assign load_c       = !bus.stall && !squash_c && !fetch_done_c;

   // Stall outranks redirects: ID keeps the redirect asserted until the stall drops.
   always_comb begin
      pc_d = pc_q;
      if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.jump) begin
         pc_d = {bus.jump_target[XLEN-1:2], 2'b00};
      end else if (bus.branch_taken) begin
         pc_d = {bus.branch_target[XLEN-1:2], 2'b00};
      end else if (!fetch_done_c) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.jump && bus.branch_taken))
            else $warning("fetch_stage: jump and branch_taken asserted together, jump taken");
      end
   end

   ifid_reg u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (bus.stall),
      .squash_i (squash_c),
      .bubble_i (fetch_done_c),
      .instru_i (bus.im_instru),
      .pc4_i    (pc_plus4),
      .ifid_o   (ifid)
   );

   assign bus.im_addr     = pc_q;
   assign bus.fetch_done  = fetch_done_c;
   assign bus.ifid_instru = ifid.instru;
   assign bus.ifid_pc4    = ifid.pc4;
   assign bus.ifid_valid  = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] perf_fetched_q;
   logic [XLEN-1:0] perf_fetched_d;
   logic [XLEN-1:0] perf_bubbles_q;
   logic [XLEN-1:0] perf_bubbles_d;

   // Bubbles only count edges that actually load a bubble, never held (stalled) edges.
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_bubbles_d = perf_bubbles_q;
      if (load_c && (perf_fetched_q != '1)) begin
         perf_fetched_d = perf_fetched_q + XLEN'(1);
      end
      if (!bus.stall && !load_c && (perf_bubbles_q != '1)) begin
         perf_bubbles_d = perf_bubbles_q + XLEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_bubbles_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign bus.perf_fetched = perf_fetched_q;
   assign bus.perf_bubbles = perf_bubbles_q;
`else
   logic unused_load;
   assign unused_load = load_c;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random hazards/redirects vs a behavioural model.
module tb_fetch_stage;

   localparam int unsigned SIZE_IM = 128;

   logic clk;
   logic rst;
   logic [31:0] mem [SIZE_IM];

   int n_cmp;
   int n_mis;

   logic [31:0] m_pc;
   logic [31:0] m_instru;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_fetched;
   logic [31:0] m_bubbles;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'h0), .SIZE_IM(SIZE_IM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory; out-of-window reads return a marker word.
   always_comb begin
      if (bus.im_addr < SIZE_IM * 4) bus.im_instru = mem[bus.im_addr[8:2]];
      else                           bus.im_instru = 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic sat_inc(inout logic [31:0] c);
      if (c != 32'hFFFF_FFFF) c = c + 1;
   endtask

   // Predict one edge from the current inputs, advance the clock, then compare everything.
   task automatic tick();
      bit   in_window;
      logic [31:0] word;
      in_window = (m_pc / 4) < SIZE_IM;
      word      = in_window ? mem[m_pc / 4] : 32'hDEAD_BEEF;
      if (rst) begin
         m_pc = 0; m_instru = 0; m_pc4 = 0; m_valid = 0;
         m_fetched = 0; m_bubbles = 0;
      end else if (!bus.stall) begin
         if (bus.flush || bus.jump || bus.branch_taken) begin
            m_instru = 0; m_pc4 = 0; m_valid = 0;
            sat_inc(m_bubbles);
         end else if (!in_window) begin
            m_instru = 0; m_valid = 0;
            sat_inc(m_bubbles);
         end else begin
            m_instru = word; m_pc4 = m_pc + 4; m_valid = 1;
            sat_inc(m_fetched);
         end
         if (bus.jump)              m_pc = bus.jump_target & ~32'h3;
         else if (bus.branch_taken) m_pc = bus.branch_target & ~32'h3;
         else if (in_window)        m_pc = m_pc + 4;
      end
      @(posedge clk);
      #1;
      chk("im_addr",     bus.im_addr,     m_pc);
      chk("fetch_done",  32'(bus.fetch_done), 32'((m_pc / 4) >= SIZE_IM));
      chk("ifid_instru", bus.ifid_instru, m_instru);
      chk("ifid_pc4",    bus.ifid_pc4,    m_pc4);
      chk("ifid_valid",  32'(bus.ifid_valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", bus.perf_fetched, m_fetched);
      chk("perf_bubbles", bus.perf_bubbles, m_bubbles);
`endif
   endtask

   task automatic clear_ctl();
      bus.stall = 0; bus.flush = 0; bus.jump = 0; bus.branch_taken = 0;
      bus.jump_target = 0; bus.branch_target = 0;
   endtask

   initial begin
      logic [31:0] held_pc;
      logic [31:0] held_bub;
      n_cmp = 0;
      n_mis = 0;
      m_pc = 0; m_instru = 0; m_pc4 = 0; m_valid = 0; m_fetched = 0; m_bubbles = 0;
      for (int i = 0; i < int'(SIZE_IM); i++) mem[i] = $urandom;
      clear_ctl();

      // Reset state.
      rst = 1;
      repeat (2) tick();
      chk("rst_addr",  bus.im_addr, 32'h0);
      chk("rst_valid", 32'(bus.ifid_valid), 32'h0);

      // Free run.
      rst = 0;
      repeat (3) tick();
      chk("free_addr",   bus.im_addr, 32'd12);
      chk("free_instru", bus.ifid_instru, mem[2]);
      chk("free_pc4",    bus.ifid_pc4, 32'd12);

      // Restart and stall at pc=8.
      rst = 1; tick(); rst = 0;
      repeat (2) tick();
      bus.stall = 1;
      repeat (2) tick();
      chk("stall_addr",   bus.im_addr, 32'd8);
      chk("stall_instru", bus.ifid_instru, mem[1]);
      chk("stall_pc4",    bus.ifid_pc4, 32'd8);
      bus.stall = 0;
      tick();
      chk("resume_instru", bus.ifid_instru, mem[2]);

      // Branch at pc=12.
      bus.branch_taken = 1; bus.branch_target = 32'h40;
      tick();
      chk("br_addr",  bus.im_addr, 32'h40);
      chk("br_valid", 32'(bus.ifid_valid), 32'h0);
      clear_ctl();
      tick();
      chk("br_instru", bus.ifid_instru, mem[16]);
      chk("br_pc4",    bus.ifid_pc4, 32'h44);

      // Illegal jump+branch: jump wins.
      bus.jump = 1; bus.jump_target = 32'h20;
      bus.branch_taken = 1; bus.branch_target = 32'h40;
      tick();
      chk("jb_addr", bus.im_addr, 32'h20);
      clear_ctl();

      // Run off the end of the window.
      bus.jump = 1; bus.jump_target = 32'h1F3;
      tick();
      clear_ctl();
      repeat (7) tick();
      chk("done_flag",  32'(bus.fetch_done), 32'h1);
      chk("done_addr",  bus.im_addr, 32'd512);
      chk("done_valid", 32'(bus.ifid_valid), 32'h0);
      bus.jump = 1; bus.jump_target = 32'h0;
      tick();
      chk("done_clear", 32'(bus.fetch_done), 32'h0);
      clear_ctl();
      repeat (2) tick();

      // Stall with a pending jump.
      held_pc  = bus.im_addr;
      held_bub = m_bubbles;
      bus.stall = 1; bus.jump = 1; bus.jump_target = 32'h80;
      repeat (3) tick();
      chk("sj_hold", bus.im_addr, held_pc);
      chk("sj_bubbles_model", m_bubbles, held_bub);
      bus.stall = 0;
      tick();
      chk("sj_apply", bus.im_addr, 32'h80);
      clear_ctl();
      tick();

      // Reset during stall + redirect.
      bus.stall = 1; bus.jump = 1; bus.jump_target = 32'h100; rst = 1;
      tick();
      chk("rst_mid_addr", bus.im_addr, 32'h0);
      rst = 0; clear_ctl();
      tick();

      // Random hazards and redirects.
      for (int c = 0; c < 600; c++) begin
         int unsigned r;
         clear_ctl();
         rst       = ($urandom_range(0, 99) == 0);
         bus.stall = ($urandom_range(0, 4) == 0);
         bus.flush = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 11);
         if (r == 0) begin
            bus.jump = 1; bus.jump_target = $urandom_range(0, 600);
         end else if (r == 1) begin
            bus.branch_taken = 1; bus.branch_target = $urandom_range(0, 600);
         end
         tick();
      end
      rst = 0; clear_ctl();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
